udp_tx_arbiter: RTL and testbench
=================================

Name: udp_tx_arbiter

Overview:
- Sequences the shared UDP transmit path of mac_top between two payload requesters (channel 0 and channel 1, e.g. an echo path and a pattern generator).
- Owns ARP resolution before first send and after mac_not_exist, with timeout and retry.
- Performs round-robin grant, length hand-off, payload byte streaming into the MAC TX RAM, and inter-frame gap timing.
- Runs entirely in the gmii_tx_clk domain.

Parameters:
- GAP_CYCLES, 90, idle cycles enforced after udp_tx_end before the next arbitration.
- ARP_TIMEOUT, 125000000, cycles in ARP_WAIT before an ARP request is re-issued.
- ARP_RETRIES, 4, ARP requests issued before arp_fail is pulsed.
- MAX_LEN, 1472, largest legal payload length in bytes.

Ports:
- gmii_tx_clk  in  1  TX clock; all logic on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- src_req  in  2  per-channel frame request, level.
- src_len  in  32  payload lengths; [15:0] is channel 0, [31:16] is channel 1; must be stable while src_req is high.
- src_data  in  16  payload bytes; [7:0] is channel 0, [15:8] is channel 1.
- src_valid  in  2  per-channel byte valid.
- src_ready  out  2  per-channel byte accept.
- src_done  out  2  one-cycle pulse when the frame completes (sent or rejected).
- src_err  out  2  one-cycle pulse, coincident with src_done, when a frame is rejected.
- udp_tx_req  out  1  to mac_top.
- arp_request_req  out  1  to mac_top.
- ram_wr_en  out  1  to mac_top TX RAM.
- ram_wr_data  out  8  to mac_top TX RAM.
- udp_send_data_length  out  16  to mac_top.
- udp_ram_data_req  in  1  from mac_top.
- udp_tx_end  in  1  from mac_top.
- almost_full  in  1  from mac_top.
- mac_send_end  in  1  from mac_top.
- arp_found  in  1  from mac_top.
- mac_not_exist  in  1  from mac_top.
- grant  out  2  one-hot, active owner; 0 when none.
- arp_fail  out  1  one-cycle pulse when retries are exhausted.

Behaviour:
- Reset values:
  - All outputs are 0.
  - State IDLE; resolved flag = 0; round-robin pointer = 0 (channel 0 first); all counters = 0.
  - Reset asserted mid-frame aborts immediately with no src_done.
- States: IDLE, ARP_REQ, ARP_SEND, ARP_WAIT, ARB, GEN_REQ, WRITE, SEND, GAP.
- IDLE:
  - mac_not_exist=1 clears resolved in the same cycle.
  - If any src_req is set: when resolved=0 or mac_not_exist=1, go to ARP_REQ; otherwise, when almost_full=0, go to ARB; otherwise stay in IDLE.
- ARP_REQ: arp_request_req=1 for exactly one cycle, then ARP_SEND.
- ARP_SEND: wait for mac_send_end, then ARP_WAIT; the timeout counter starts at 0.
- ARP_WAIT:
  - arp_found: set resolved=1, clear the retry count, go to IDLE.
  - Counter reaches ARP_TIMEOUT-1: increment the retry count.
    - Retry count < ARP_RETRIES: go to ARP_REQ.
    - Retry count reaches ARP_RETRIES: pulse arp_fail, clear the retry count, go to IDLE.
  - If arp_found and the timeout occur in the same cycle, arp_found wins.
- ARB (one cycle):
  - Winner = the requesting channel at or after the pointer; with both requesting, the pointer channel wins.
  - Register grant and udp_send_data_length = winner's src_len.
  - Length 0 or > MAX_LEN: pulse src_done and src_err for the winner, advance pointer, go to GAP. No MAC activity occurs.
  - Valid length: go to GEN_REQ.
  - If the request dropped before ARB: return to IDLE.
- GEN_REQ: udp_tx_req=1 while in state; on udp_ram_data_req go to WRITE.
- WRITE:
  - src_ready[g] = (state==WRITE) && byte_cnt < len; combinational.
  - On src_valid[g]&&src_ready[g]: next cycle ram_wr_en=1 and ram_wr_data=byte; byte_cnt increments. Latency is 1 cycle.
  - src_valid low: no ram_wr_en that cycle (stall tolerated).
  - After the byte at byte_cnt == len-1 is accepted, go to SEND; the last ram_wr_en issues in the first SEND cycle.
  - The non-granted src_ready is always 0.
- SEND: wait for udp_tx_end, then pulse src_done[g], set pointer = other channel, clear grant, go to GAP.
- GAP: count GAP_CYCLES cycles, then IDLE.
- Arithmetic widths: byte_cnt 16 bits, gap counter 16 bits, ARP counter 32 bits, compared unsigned. No wrap is possible within legal lengths.

Optional Feature:
- Macro UDP_ARB_STRICT_PRIO_EN.
- Defined: channel 0 always wins ARB when requesting; the pointer is ignored.
- Undefined: round-robin as above.

Test Plan:
- ARP bring-up:
  - Stimulus: after reset, src_req=01 with len 20; mac_send_end at cycle 5; arp_found at cycle 30.
  - Response: one arp_request_req pulse; no udp_tx_req before arp_found; then GEN_REQ, 20 ram_wr_en, src_done[0] after udp_tx_end.
- ARP timeout:
  - Stimulus: ARP_TIMEOUT=100, ARP_RETRIES=4, no arp_found.
  - Response: 4 arp_request_req pulses spaced 100+ cycles apart, then arp_fail pulse; no udp_tx_req.
- Fairness:
  - Stimulus: both channels request continuously, len 16, resolved.
  - Response: grants alternate 01,10,01,10; frames separated by >= GAP_CYCLES cycles after udp_tx_end.
- Stall and length:
  - Stimulus: len 5; src_valid toggles 1,0,1,1,0,1,1.
  - Response: exactly 5 ram_wr_en carrying the accepted bytes in order; src_ready drops after the 5th accept.
- Rejects:
  - Stimulus: len 0, then len 1473.
  - Response: src_done+src_err pulse in the ARB cycle; no udp_tx_req; next requester served after the gap.
- Back-pressure and mac_not_exist:
  - Stimulus: almost_full=1 in IDLE holds the block; mac_not_exist=1 with req pending.
  - Response: the block stays in IDLE while almost_full=1; mac_not_exist forces ARP_REQ before the next frame.

Source files
------------

// File: rtl/udp_tx_arbiter.sv
// udp_tx_arbiter: ARP bring-up, two-channel UDP TX arbitration, payload streaming and frame gap; define UDP_ARB_STRICT_PRIO_EN for fixed channel-0 priority
module udp_tx_arbiter #(
  parameter int GAP_CYCLES  = 90,
  parameter int ARP_TIMEOUT = 125000000,
  parameter int ARP_RETRIES = 4,
  parameter int MAX_LEN     = 1472
) (
  input  logic        gmii_tx_clk,
  input  logic        rst,
  input  logic [1:0]  src_req,
  input  logic [31:0] src_len,
  input  logic [15:0] src_data,
  input  logic [1:0]  src_valid,
  output logic [1:0]  src_ready,
  output logic [1:0]  src_done,
  output logic [1:0]  src_err,
  output logic        udp_tx_req,
  output logic        arp_request_req,
  output logic        ram_wr_en,
  output logic [7:0]  ram_wr_data,
  output logic [15:0] udp_send_data_length,
  input  logic        udp_ram_data_req,
  input  logic        udp_tx_end,
  input  logic        almost_full,
  input  logic        mac_send_end,
  input  logic        arp_found,
  input  logic        mac_not_exist,
  output logic [1:0]  grant,
  output logic        arp_fail
);
  typedef enum logic [3:0] {IDLE, ARP_REQ, ARP_SEND, ARP_WAIT, ARB, GEN_REQ, WRITE, SEND, GAP} state_t;
  localparam logic [15:0] GAP_LAST  = 16'(GAP_CYCLES - 1);
  localparam logic [31:0] ARP_LAST  = 32'(ARP_TIMEOUT - 1);
  localparam logic [7:0]  RETRY_MAX = 8'(ARP_RETRIES);
  localparam logic [15:0] LEN_MAX   = 16'(MAX_LEN);
  state_t      state_q, state_d;
  logic        resolved_q, resolved_d;
  logic        ptr_q, ptr_d;
  logic [7:0]  retry_q, retry_d;
  logic [31:0] arp_cnt_q, arp_cnt_d;
  logic [15:0] gap_cnt_q, gap_cnt_d;
  logic [15:0] byte_cnt_q, byte_cnt_d;
  logic [1:0]  grant_q, grant_d;
  logic [15:0] len_q, len_d;
  logic        wr_en_q, wr_en_d;
  logic [7:0]  wr_data_q, wr_data_d;
  logic        win1, acc;
  logic [1:0]  win_oh;
  logic [15:0] win_len;
  logic [7:0]  cur_byte, retry_inc;
`ifdef UDP_ARB_STRICT_PRIO_EN
  assign win1 = !src_req[0];
`else
  assign win1 = ptr_q ? src_req[1] : !src_req[0];
`endif
  assign win_oh    = win1 ? 2'b10 : 2'b01;
  assign win_len   = win1 ? src_len[31:16] : src_len[15:0];
  assign src_ready = (state_q == WRITE && byte_cnt_q < len_q) ? grant_q : 2'b00;
  assign acc       = |(src_valid & src_ready);
  assign cur_byte  = grant_q[1] ? src_data[15:8] : src_data[7:0];
  assign retry_inc = retry_q + 8'd1;
  assign udp_tx_req           = state_q == GEN_REQ;
  assign arp_request_req      = state_q == ARP_REQ;
  assign grant                = grant_q;
  assign udp_send_data_length = len_q;
  assign ram_wr_en            = wr_en_q;
  assign ram_wr_data          = wr_data_q;
  // Next-state, counters and one-cycle pulses of the transmit sequencer
  always_comb begin
    state_d    = state_q;
    resolved_d = resolved_q;
    ptr_d      = ptr_q;
    retry_d    = retry_q;
    arp_cnt_d  = arp_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    byte_cnt_d = byte_cnt_q;
    grant_d    = grant_q;
    len_d      = len_q;
    wr_en_d    = 1'b0;
    wr_data_d  = wr_data_q;
    src_done   = 2'b00;
    src_err    = 2'b00;
    arp_fail   = 1'b0;
    case (state_q)
      IDLE: begin
        if (mac_not_exist) resolved_d = 1'b0;
        if (|src_req) state_d = (!resolved_q || mac_not_exist) ? ARP_REQ : (!almost_full ? ARB : IDLE);
      end
      ARP_REQ: state_d = ARP_SEND;
      ARP_SEND: if (mac_send_end) begin
        arp_cnt_d = 32'd0;
        state_d   = ARP_WAIT;
      end
      ARP_WAIT: begin
        arp_cnt_d = arp_cnt_q + 32'd1;
        if (arp_found) begin
          resolved_d = 1'b1;
          retry_d    = 8'd0;
          state_d    = IDLE;
        end else if (arp_cnt_q == ARP_LAST) begin
          arp_fail = retry_inc >= RETRY_MAX;
          retry_d  = arp_fail ? 8'd0 : retry_inc;
          state_d  = arp_fail ? IDLE : ARP_REQ;
        end
      end
      ARB: begin
        if (!(|src_req)) state_d = IDLE;
        else if (win_len == 16'd0 || win_len > LEN_MAX) begin
          len_d     = win_len;
          src_done  = win_oh;
          src_err   = win_oh;
          ptr_d     = !win1;
          gap_cnt_d = 16'd0;
          state_d   = GAP;
        end else begin
          len_d      = win_len;
          grant_d    = win_oh;
          byte_cnt_d = 16'd0;
          state_d    = GEN_REQ;
        end
      end
      GEN_REQ: if (udp_ram_data_req) state_d = WRITE;
      WRITE: if (acc) begin
        wr_en_d    = 1'b1;
        wr_data_d  = cur_byte;
        byte_cnt_d = byte_cnt_q + 16'd1;
        if (byte_cnt_q == len_q - 16'd1) state_d = SEND;
      end
      SEND: if (udp_tx_end) begin
        src_done  = grant_q;
        ptr_d     = !grant_q[1];
        grant_d   = 2'b00;
        gap_cnt_d = 16'd0;
        state_d   = GAP;
      end
      GAP: begin
        gap_cnt_d = gap_cnt_q + 16'd1;
        if (gap_cnt_q == GAP_LAST) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  // State and datapath registers
  always_ff @(posedge gmii_tx_clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      resolved_q <= 1'b0;
      ptr_q      <= 1'b0;
      retry_q    <= 8'd0;
      arp_cnt_q  <= 32'd0;
      gap_cnt_q  <= 16'd0;
      byte_cnt_q <= 16'd0;
      grant_q    <= 2'b00;
      len_q      <= 16'd0;
      wr_en_q    <= 1'b0;
      wr_data_q  <= 8'd0;
    end else begin
      state_q    <= state_d;
      resolved_q <= resolved_d;
      ptr_q      <= ptr_d;
      retry_q    <= retry_d;
      arp_cnt_q  <= arp_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      grant_q    <= grant_d;
      len_q      <= len_d;
      wr_en_q    <= wr_en_d;
      wr_data_q  <= wr_data_d;
    end
  end
endmodule

// File: tb/tb_udp_tx_arbiter.sv
// tb_udp_tx_arbiter: scoreboard bench for udp_tx_arbiter (default round-robin build)
module tb_udp_tx_arbiter;
  localparam int GAP = 10;
  localparam int TO  = 100;
  localparam int RET = 4;
  logic clk = 1'b0;
  logic rst;
  logic [1:0] src_req, src_valid, src_ready, src_done, src_err, grant;
  logic [31:0] src_len;
  logic [15:0] src_data, udp_send_data_length;
  logic udp_tx_req, arp_request_req, ram_wr_en, arp_fail;
  logic [7:0] ram_wr_data;
  logic udp_ram_data_req, udp_tx_end, almost_full, mac_send_end, arp_found, mac_not_exist;
  int checks = 0, errors = 0;
  int cyc_n = 0, n_wr = 0;
  int t_req = 0, t_end = 0, t_rej = 0, exp_ptr = 0;
  logic [7:0] seed = 8'h11;
  logic [7:0] exp_q[$];

  udp_tx_arbiter #(.GAP_CYCLES(GAP), .ARP_TIMEOUT(TO), .ARP_RETRIES(RET), .MAX_LEN(1472)) dut (
    .gmii_tx_clk(clk), .rst(rst), .src_req(src_req), .src_len(src_len), .src_data(src_data),
    .src_valid(src_valid), .src_ready(src_ready), .src_done(src_done), .src_err(src_err),
    .udp_tx_req(udp_tx_req), .arp_request_req(arp_request_req), .ram_wr_en(ram_wr_en),
    .ram_wr_data(ram_wr_data), .udp_send_data_length(udp_send_data_length),
    .udp_ram_data_req(udp_ram_data_req), .udp_tx_end(udp_tx_end), .almost_full(almost_full),
    .mac_send_end(mac_send_end), .arp_found(arp_found), .mac_not_exist(mac_not_exist),
    .grant(grant), .arp_fail(arp_fail));

  always #5 clk = ~clk;
  always @(posedge clk) cyc_n++;

  // RAM write scoreboard and grant/ready consistency
  always @(negedge clk) begin
    if (ram_wr_en) begin
      n_wr++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL wr_extra: ram_wr_en with data %02h but no byte expected", ram_wr_data);
      end else begin
        automatic logic [7:0] e = exp_q.pop_front();
        if (ram_wr_data !== e) begin
          errors++;
          $display("FAIL wr_data: got %02h expected %02h", ram_wr_data, e);
        end
      end
    end
    checks++;
    if ((src_ready & ~grant) !== 2'b00) begin
      errors++;
      $display("FAIL ready_mask: src_ready %b grant %b", src_ready, grant);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_frame(input int ch, input int len, input logic [7:0] pat, input int patn, input bit drop);
    logic [1:0] oh;
    int acc, w0;
    bit seen;
    oh = (ch == 1) ? 2'b10 : 2'b01;
    w0 = n_wr;
    seen = 0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk);
      if (udp_tx_req) seen = 1; else cyc();
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL frame_req: no udp_tx_req within 400 cycles for ch %0d", ch);
      return;
    end
    t_req = cyc_n;
    checks++;
    if (grant !== oh) begin errors++; $display("FAIL frame_grant: got %b expected %b", grant, oh); end
    checks++;
    if (udp_send_data_length !== 16'(len)) begin
      errors++;
      $display("FAIL frame_len: got %0d expected %0d", udp_send_data_length, len);
    end
    cyc(); udp_ram_data_req = 1'b1;
    cyc(); udp_ram_data_req = 1'b0;
    acc = 0;
    for (int i = 0; i < 200 && acc < len; i++) begin
      src_valid = pat[i % patn] ? oh : 2'b00;
      src_data = {2{seed + 8'(acc)}};
      @(negedge clk);
      if ((src_valid & src_ready) != 2'b00) begin
        exp_q.push_back(src_data[8*ch +: 8]);
        acc++;
      end
      if (acc < len) cyc();
    end
    checks++;
    if (acc != len) begin errors++; $display("FAIL frame_accept: accepted %0d expected %0d", acc, len); end
    cyc(); src_valid = 2'b00;
    @(negedge clk);
    checks++;
    if (src_ready !== 2'b00) begin errors++; $display("FAIL ready_after_last: got %b expected 00", src_ready); end
    cyc();
    if (drop) src_req[ch] = 1'b0;
    repeat (2) cyc();
    udp_tx_end = 1'b1;
    @(negedge clk);
    checks++;
    if (src_done !== oh || src_err !== 2'b00) begin
      errors++;
      $display("FAIL frame_done: done %b err %b expected done %b err 00", src_done, src_err, oh);
    end
    t_end = cyc_n;
    cyc(); udp_tx_end = 1'b0;
    checks++;
    if (n_wr - w0 != len) begin errors++; $display("FAIL wr_count: got %0d expected %0d", n_wr - w0, len); end
    exp_ptr = (ch == 1) ? 0 : 1;
    seed = seed + 8'd53;
  endtask

  task automatic arp_handshake(input int found_delay);
    int nreq, nudp;
    bit seen;
    seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (arp_request_req) seen = 1; else cyc();
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL arp_req_seen: no arp_request_req within 100 cycles"); return; end
    nreq = 1;
    nudp = 0;
    cyc(); mac_send_end = 1'b1;
    for (int i = 0; i < found_delay; i++) begin
      @(negedge clk);
      if (arp_request_req) nreq++;
      if (udp_tx_req) nudp++;
      cyc(); mac_send_end = 1'b0;
    end
    arp_found = 1'b1;
    @(negedge clk);
    if (udp_tx_req) nudp++;
    cyc(); arp_found = 1'b0;
    checks++;
    if (nreq != 1) begin errors++; $display("FAIL arp_req_count: got %0d expected 1", nreq); end
    checks++;
    if (nudp != 0) begin errors++; $display("FAIL udp_before_arp: %0d udp_tx_req cycles expected 0", nudp); end
  endtask

  task automatic wait_reject(input logic [1:0] oh);
    int nudp;
    bit seen;
    seen = 0;
    nudp = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (src_done != 2'b00) seen = 1;
      else begin
        if (udp_tx_req) nudp++;
        cyc();
      end
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL reject_seen: no src_done within 100 cycles"); return; end
    t_rej = cyc_n;
    checks++;
    if (src_done !== oh || src_err !== oh) begin
      errors++;
      $display("FAIL reject_pulse: done %b err %b expected %b/%b", src_done, src_err, oh, oh);
    end
    checks++;
    if (nudp != 0 || udp_tx_req !== 1'b0) begin errors++; $display("FAIL reject_udp: udp_tx_req seen, expected none"); end
    cyc();
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({grant, src_ready, src_done, src_err} !== 8'h00) begin
      errors++;
      $display("FAIL reset_ch: grant %b ready %b done %b err %b expected all 0", grant, src_ready, src_done, src_err);
    end
    checks++;
    if ({udp_tx_req, arp_request_req, ram_wr_en, arp_fail} !== 4'h0) begin
      errors++;
      $display("FAIL reset_ctl: udp %b arp %b wr %b fail %b expected 0", udp_tx_req, arp_request_req, ram_wr_en, arp_fail);
    end
    checks++;
    if (ram_wr_data !== 8'h00 || udp_send_data_length !== 16'h0000) begin
      errors++;
      $display("FAIL reset_data: wr_data %02h len %0d expected 0", ram_wr_data, udp_send_data_length);
    end
    cyc(); rst = 1'b0;
  endtask

  task automatic test_arp_bringup();
    src_len = {16'd0, 16'd20};
    src_req = 2'b01;
    arp_handshake(25);
    do_frame(0, 20, 8'h01, 1, 1'b1);
  endtask

  task automatic test_fairness();
    int prev;
    src_len = {16'd16, 16'd16};
    src_req = 2'b11;
    for (int k = 0; k < 4; k++) begin
      prev = t_end;
      do_frame(exp_ptr, 16, 8'h01, 1, 1'b0);
      if (k > 0) begin
        checks++;
        if (t_req - prev != GAP + 3) begin
          errors++;
          $display("FAIL fair_gap: %0d cycles from udp_tx_end to udp_tx_req expected %0d", t_req - prev, GAP + 3);
        end
      end
    end
    src_req = 2'b00;
  endtask

  task automatic test_stall();
    src_len = {16'd0, 16'd5};
    src_req = 2'b01;
    do_frame(0, 5, 8'h6D, 7, 1'b1);
  endtask

  task automatic test_rejects();
    src_len = {16'd0, 16'd0};
    src_req = 2'b01;
    wait_reject(2'b01);
    src_req = 2'b00;
    src_len = {16'd1473, 16'd8};
    src_req = 2'b11;
    wait_reject(2'b10);
    src_req = 2'b01;
    do_frame(0, 8, 8'h01, 1, 1'b1);
    checks++;
    if (t_req - t_rej != GAP + 3) begin
      errors++;
      $display("FAIL reject_gap: %0d cycles from reject to udp_tx_req expected %0d", t_req - t_rej, GAP + 3);
    end
  endtask

  task automatic test_backpressure();
    int nudp, narp;
    almost_full = 1'b1;
    src_len = {16'd0, 16'd4};
    src_req = 2'b01;
    nudp = 0;
    narp = 0;
    repeat (GAP + 20) begin
      @(negedge clk);
      if (udp_tx_req) nudp++;
      if (arp_request_req) narp++;
      cyc();
    end
    checks++;
    if (nudp != 0 || narp != 0) begin
      errors++;
      $display("FAIL af_hold: udp %0d arp %0d cycles while almost_full, expected 0/0", nudp, narp);
    end
    almost_full = 1'b0;
    do_frame(0, 4, 8'h01, 1, 1'b1);
    almost_full = 1'b1;
    src_req = 2'b01;
    repeat (GAP + 5) cyc();
    mac_not_exist = 1'b1;
    cyc(); mac_not_exist = 1'b0;
    almost_full = 1'b0;
    arp_handshake(10);
    do_frame(0, 4, 8'h01, 1, 1'b1);
  endtask

  task automatic test_arp_timeout();
    int req_t[8];
    int nreq, nudp, pend;
    bit failed;
    rst = 1'b1;
    cyc(); cyc(); rst = 1'b0;
    src_len = {16'd0, 16'd20};
    src_req = 2'b01;
    nreq = 0;
    nudp = 0;
    pend = 0;
    failed = 0;
    for (int i = 0; i < 1000 && !failed; i++) begin
      mac_send_end = pend[0];
      pend = 0;
      @(negedge clk);
      if (arp_request_req) begin
        if (nreq < 8) req_t[nreq] = cyc_n;
        nreq++;
        pend = 1;
      end
      if (udp_tx_req) nudp++;
      if (arp_fail) failed = 1;
      cyc();
    end
    mac_send_end = 1'b0;
    src_req = 2'b00;
    checks++;
    if (!failed) begin errors++; $display("FAIL arp_fail_seen: no arp_fail within 1000 cycles"); end
    checks++;
    if (nreq != RET) begin errors++; $display("FAIL arp_retry_count: got %0d requests expected %0d", nreq, RET); end
    for (int k = 1; k < nreq && k < 8; k++) begin
      checks++;
      if (req_t[k] - req_t[k-1] < TO) begin
        errors++;
        $display("FAIL arp_spacing: request %0d after %0d cycles expected >= %0d", k, req_t[k] - req_t[k-1], TO);
      end
    end
    checks++;
    if (nudp != 0) begin errors++; $display("FAIL arp_fail_udp: %0d udp_tx_req cycles expected 0", nudp); end
    repeat (5) cyc();
  endtask

  initial begin
    rst = 1'b1;
    src_req = 2'b00;
    src_len = 32'd0;
    src_data = 16'd0;
    src_valid = 2'b00;
    udp_ram_data_req = 1'b0;
    udp_tx_end = 1'b0;
    almost_full = 1'b0;
    mac_send_end = 1'b0;
    arp_found = 1'b0;
    mac_not_exist = 1'b0;
    test_reset();
    test_arp_bringup();
    test_fairness();
    test_stall();
    test_rejects();
    test_backpressure();
    test_arp_timeout();
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL wr_missing: %0d expected bytes never written", exp_q.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
